i_arbiter_rr: RTL and testbench
===============================

# i_arbiter_rr

Round-robin arbiter sharing one resource among 2**SIZE requesters. Requests and grants are active-low, matching the inverted-input encoder convention used in this block family. The arbiter issues a one-hot active-low grant plus its binary index, so downstream muxes can select directly. It sits in front of a shared datapath port (bus, encoder, memory) and sequences access between requesters.

## Interface
- SIZE, 2, index width; number of requesters N = 2**SIZE
- HOLD_MAX, 8, maximum grant length in cycles when timeout is compiled in; legal range 1..255
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_n  input  N  request per requester, active-low; held low for as long as access is wanted
- gnt_n  output  N  grant, active-low, one-hot or all ones
- gnt_idx  output  SIZE  binary index of granted requester; 0 when no grant
- gnt_valid  output  1  high while a grant is active
- busy  output  1  high in GRANT and GAP states
- preempt  output  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- All outputs are registered.
- Reset values: gnt_n all ones, gnt_idx 0, gnt_valid 0, busy 0, preempt 0. Internal values: state IDLE, last = N-1, hold counter 0.
- FSM states:
  - IDLE: no grant. If any req_n bit is low, grant the first low bit found searching from (last+1) mod N upward with wrap. Go to GRANT. Otherwise stay in IDLE.
  - GRANT: gnt_n[idx]=0, gnt_idx=idx, gnt_valid=1. If req_n[idx] is sampled high (release), set last=idx and go to GAP with all grant outputs deasserted.
  - GAP: one cycle with no grant. Always goes to IDLE.
- Other requesters' req_n changes during GRANT are ignored until re-arbitration.
- Simultaneous requests are resolved by round-robin order only; there is no fixed priority beyond the pointer.
- Because last resets to N-1, requester 0 has first priority after reset.
- A requester that releases and immediately re-requests moves to lowest priority.
- rst dominates every state, including mid-grant. Reset values are restored at that edge; no GAP cycle is inserted.

## Timing
- Grant latency: with req_n sampled low at edge e in IDLE, gnt_n, gnt_idx and gnt_valid are valid after edge e (1 cycle).
- Release: with req_n[idx] sampled high at edge e, the grant is deasserted after edge e.
- Turnaround: GAP occupies edge e+1 and IDLE arbitrates at edge e+2. Grant outputs are therefore inactive for exactly 2 cycles between consecutive grants.
- gnt_idx changes only together with gnt_n; it never glitches mid-grant.
- busy rises with gnt_valid and falls 1 cycle after gnt_valid falls.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- With ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - If the counter equals HOLD_MAX-1 and req_n[idx] is still low, the next edge forces GAP. That edge also sets last=idx and pulses preempt for one cycle.
  - A release on the same edge takes precedence: normal GAP, no preempt.
  - Each grant lasts at most HOLD_MAX cycles.
- Without ARB_TIMEOUT_EN:
  - There is no counter.
  - A grant is held until release.
  - HOLD_MAX is ignored and preempt is tied to 0.

## Test plan
- Single request: SIZE=2; reset, then req_n=4'b1110. One edge later: gnt_n=1110, gnt_idx=0, gnt_valid=1, busy=1.
- Fairness: req_n=4'b0000. Each granted requester holds 3 cycles, releases for 1 cycle, then re-requests. Required grant order: 0,1,2,3,0. Each grant is separated by exactly 2 cycles of gnt_valid=0.
- Release/turnaround: requester 0 granted with req_n=1100; drive req_n=1101 at edge e. Required sequence: gnt_n=1111 after e, still 1111 after e+1, 1101 with gnt_idx=1 after e+2.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): req_n=1100 held constant. Required sequence: grant 0 for 4 cycles, then preempt=1 for 1 cycle, 2 idle cycles, grant 1 for 4 cycles, then grant 0 again.
- Reset mid-grant: assert rst for 1 cycle while requester 2 is granted. After that edge all outputs are at reset values. The next grant with req_n=1011 and 1110 both low goes to requester 0 first.
- No timeout (macro undefined): req_n=1110 held 100 cycles. gnt_n stays 1110 and preempt stays 0 throughout.

Source files
------------

// File: rtl/i_arbiter_rr.sv
// i_arbiter_rr: round-robin arbiter over 2**SIZE active-low requesters.
// Issues a one-hot active-low grant plus its binary index. Every grant is
// followed by a one-cycle GAP and then an IDLE arbitration cycle.
// Optional grant timeout is compiled in with `define ARB_TIMEOUT_EN; the
// default build holds a grant until release and ties preempt low.
module i_arbiter_rr #(
  parameter int unsigned SIZE     = 2,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [(1<<SIZE)-1:0]   req_n,
  output logic [(1<<SIZE)-1:0]   gnt_n,
  output logic [SIZE-1:0]        gnt_idx,
  output logic                   gnt_valid,
  output logic                   busy,
  output logic                   preempt
);

  localparam int unsigned N = 1 << SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Reject an illegal timeout length at elaboration
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("i_arbiter_rr: HOLD_MAX must be in 1..255");
  end

  state_t            state_q, state_d;
  logic [SIZE-1:0]   last_q, last_d;
  logic [SIZE-1:0]   idx_q, idx_d;
  logic [N-1:0]      gnt_n_d;
  logic [SIZE-1:0]   gnt_idx_d;
  logic              gnt_valid_d;
  logic              busy_d;

  logic [SIZE-1:0]   pick;
  logic              found;
  logic [SIZE-1:0]   cand;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0]        cnt_q, cnt_d;
  logic              preempt_d;
`endif

  // Round-robin search: first low request starting at last+1, wrapping
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = last_q + SIZE'(i + 1);
      if (!found && !req_n[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    idx_d       = idx_q;
    gnt_n_d     = '1;
    gnt_idx_d   = '0;
    gnt_valid_d = 1'b0;
    busy_d      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    preempt_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = GRANT;
          idx_d       = pick;
          gnt_n_d     = ~(N'(1) << pick);
          gnt_idx_d   = pick;
          gnt_valid_d = 1'b1;
          busy_d      = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (req_n[idx_q]) begin
          // Release: the owner drops to lowest priority
          state_d = GAP;
          last_d  = idx_q;
          busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == HOLD_LAST) begin
          // Grant has run its full length: revoke it
          state_d   = GAP;
          last_d    = idx_q;
          busy_d    = 1'b1;
          preempt_d = 1'b1;
`endif
        end else begin
          gnt_n_d     = ~(N'(1) << idx_q);
          gnt_idx_d   = idx_q;
          gnt_valid_d = 1'b1;
          busy_d      = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = cnt_q + 8'd1;
`endif
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= SIZE'(N - 1);
      idx_q     <= '0;
      gnt_n     <= '1;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      gnt_n     <= gnt_n_d;
      gnt_idx   <= gnt_idx_d;
      gnt_valid <= gnt_valid_d;
      busy      <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and preempt pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      preempt <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      preempt <= preempt_d;
    end
  end
`else
  assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_i_arbiter_rr.sv
// tb_i_arbiter_rr: directed scenarios plus random request traffic, each
// cycle compared against a grant-ownership reference model.
module tb_i_arbiter_rr;

  localparam int unsigned SIZE = 2;
  localparam int unsigned N    = 1 << SIZE;
  localparam int          HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_n;
  logic [N-1:0]    gnt_n;
  logic [SIZE-1:0] gnt_idx;
  logic            gnt_valid;
  logic            busy;
  logic            preempt;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the resource, cooldown after a grant ends
  int m_owner;
  int m_cool;
  int m_last;
  int m_held;
  int m_pre;

  i_arbiter_rr #(.SIZE(SIZE), .HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_n     (req_n),
    .gnt_n     (gnt_n),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .busy      (busy),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic rs);
    bit hit;
    if (rs) begin
      m_owner = -1; m_cool = 0; m_last = N - 1; m_held = 0; m_pre = 0;
    end else begin
      m_pre = 0;
      if (m_owner >= 0) begin
        if (r[m_owner]) begin
          m_last = m_owner; m_owner = -1; m_cool = 1;
        end else if (TO && m_held == HOLD) begin
          m_last = m_owner; m_owner = -1; m_cool = 1; m_pre = 1;
        end else begin
          m_held++;
        end
      end else if (m_cool > 0) begin
        m_cool = 0;
      end else begin
        hit = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!hit && !r[(m_last + k) % N]) begin
            hit = 1'b1;
            m_owner = (m_last + k) % N;
            m_held = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]    e_gnt;
    logic [SIZE-1:0] e_idx;
    e_gnt = '1;
    e_idx = '0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b0;
      e_idx = SIZE'(m_owner);
    end
    chk("gnt_n",     32'(gnt_n),     32'(e_gnt));
    chk("gnt_idx",   32'(gnt_idx),   32'(e_idx));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("busy",      32'(busy),      32'(m_owner >= 0 || m_cool > 0));
    chk("preempt",   32'(preempt),   32'(m_pre));
  endtask

  // Drive inputs, clock once, advance model, compare away from the edge
  task automatic step(input logic [N-1:0] r, input logic rs);
    req_n = r;
    rst   = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step('1, 1'b1);
    step('1, 1'b1);
  endtask

  initial begin
    int order[$];
    int gap_run;
    int seen;
    logic [N-1:0] r;
    logic rs;

    req_n = '1;
    rst   = 1'b1;
    m_owner = -1; m_cool = 0; m_last = N - 1; m_held = 0; m_pre = 0;
    #1;
    do_reset();
    chk("reset_gnt_n", 32'(gnt_n), 32'hF);

    // Single request
    step(4'b1110, 1'b0);
    chk("single_gnt_n", 32'(gnt_n), 32'hE);
    chk("single_busy", 32'(busy), 32'd1);

    // Release / turnaround
    do_reset();
    step(4'b1100, 1'b0);
    chk("turn_first", 32'(gnt_idx), 32'd0);
    step(4'b1101, 1'b0);
    chk("turn_e1", 32'(gnt_n), 32'hF);
    step(4'b1101, 1'b0);
    chk("turn_e2", 32'(gnt_n), 32'hF);
    step(4'b1101, 1'b0);
    chk("turn_e3_gnt", 32'(gnt_n), 32'hD);
    chk("turn_e3_idx", 32'(gnt_idx), 32'd1);

    // Reset mid-grant, then requester 0 wins first
    do_reset();
    step(4'b1011, 1'b0);
    chk("mid_owner2", 32'(gnt_idx), 32'd2);
    step(4'b1011, 1'b1);
    chk("mid_rst_valid", 32'(gnt_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    step(4'b1010, 1'b0);
    chk("mid_next_idx", 32'(gnt_idx), 32'd0);

    // Fairness: all request, each owner holds 3 cycles then releases once
    do_reset();
    order = {};
    gap_run = 0;
    seen = 0;
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      r = '0;
      if (m_owner >= 0 && m_held == 3) r[m_owner] = 1'b1;
      seen = m_owner;
      step(r, 1'b0);
      if (m_owner < 0) gap_run++;
      else if (seen < 0) begin
        if (order.size() > 0) chk("fair_gap", 32'(gap_run), 32'd2);
        order.push_back(m_owner);
        gap_run = 0;
      end
    end
    chk("fair_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size(); i++)
      chk("fair_order", 32'(order[i]), 32'(i % N));

    // Held request: timeout behaviour or indefinite hold
    do_reset();
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 14; c++) begin
      step(4'b1100, 1'b0);
      if (c == 4) chk("to_grant0_last", 32'(gnt_valid), 32'd1);
      if (c == 5) chk("to_preempt", 32'(preempt), 32'd1);
      if (c == 7) chk("to_grant1", 32'(gnt_idx), 32'd1);
      if (c == 13) chk("to_grant0_again", 32'(gnt_n), 32'hE);
    end
`else
    for (int c = 0; c < 100; c++) begin
      step(4'b1110, 1'b0);
      chk("hold_gnt_n", 32'(gnt_n), 32'hE);
      chk("hold_preempt", 32'(preempt), 32'd0);
    end
`endif

    // Random traffic: requests toggle occasionally, rare resets
    do_reset();
    r = '1;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      rs = ($urandom_range(99) == 0);
      step(r, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
